data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words held.
REQ-002 Parameter IDX_W, default 8, word-index width, equal to log2(DEPTH).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 MemRead  input  1  read request from the pipeline MEM stage.
REQ-006 MemWrite  input  1  write request from the pipeline MEM stage.
REQ-007 DataAddr  input  32  byte address of the access.
REQ-008 WriteMem  input  32  store data.
REQ-009 DataMemOut  output  32  load data, combinational.
REQ-010 MemReady  output  1  high when accesses are serviced; wired to the stall logic.
REQ-011 ErrFlag  output  1  sticky access-error indicator.
REQ-012 ErrCode  output  2  type of the most recent error: 0 none, 1 misaligned, 2 out-of-range, 3 read+write conflict.

Function
REQ-013 The block SHALL implement a two-state FSM with states CLEAR and READY.
REQ-014 In CLEAR, the block SHALL write zero to word clr_idx each cycle, with clr_idx counting 0 to DEPTH-1.
- After the word DEPTH-1 is written, the FSM SHALL enter READY on the next edge (DEPTH cycles total).
REQ-015 MemReady SHALL be 1 only in READY; it is combinational from the state register.
REQ-016 In CLEAR, the block SHALL ignore all requests, never flag them, and drive DataMemOut=0.
REQ-017 An access SHALL be valid when MemReady=1, DataAddr[1:0]==0 and DataAddr[31:IDX_W+2]==0.
- Word index = DataAddr[IDX_W+1:2].
REQ-018 A valid read (MemRead=1, MemWrite=0) SHALL drive DataMemOut = mem[index] in the same cycle, zero latency.
- In every other case DataMemOut SHALL be 0.
REQ-019 A valid write (MemWrite=1, MemRead=0) SHALL update mem[index] with WriteMem on the rising edge.
REQ-020 A read of the address written in the same cycle SHALL return the old contents; the new value is visible from the next cycle.
REQ-021 MemRead=1 and MemWrite=1 together in READY SHALL perform no access and report error code 3.
REQ-022 A misaligned request SHALL perform no access and report error code 1.
- Misaligned takes priority over out-of-range; the conflict check (code 3) takes priority over both.
REQ-023 An out-of-range request SHALL perform no access and report error code 2.
REQ-024 On any reported error, the block SHALL set ErrFlag=1 (sticky until reset) and load ErrCode on the edge.
REQ-025 Requests with MemRead=0 and MemWrite=0 SHALL have no effect, regardless of DataAddr.

Reset
REQ-026 Asserting rst (low) SHALL immediately force the following, with DataMemOut=0 following from CLEAR:
- state to CLEAR, clr_idx to 0
- MemReady=0, ErrFlag=0, ErrCode=0
REQ-027 Reset asserted mid-CLEAR or mid-READY SHALL restart the clear sequence from word 0 after deassertion.
REQ-028 Memory array contents SHALL NOT be reset asynchronously; they are cleared only by the CLEAR sequence.

Structure
REQ-029 A shared package SHALL hold the state enum (CLEAR, READY), the ErrCode constants and the default DEPTH/IDX_W.
REQ-030 The storage SHALL be a sub-module dmem_array: one combinational read port and one synchronous write port.
- The FSM, clear counter and error logic stay in data_mem_responder.

Verification
REQ-031 Clear timing: release rst -> MemReady=0 for exactly 256 cycles, then 1; a read of every word returns 0x00000000.
REQ-032 Write/read: write 0xDEADBEEF to 0x00000010, then read 0x00000010 -> DataMemOut=0xDEADBEEF on the following cycle.
- A same-cycle read during the write returns 0.
REQ-033 Misaligned: write to 0x00000013 -> ErrFlag=1, ErrCode=1, word 4 unchanged.
- A subsequent valid access leaves ErrFlag=1.
REQ-034 Out-of-range: read 0x00000400 -> DataMemOut=0, ErrCode=2.
- Then MemRead=MemWrite=1 at 0x0 -> ErrCode=3, word 0 unchanged.
REQ-035 Reset mid-operation: assert rst at clear cycle 100 and in READY after writing 0x12345678 to 0x0 -> MemReady drops at once.
- After release, MemReady rises 256 cycles later and word 0 reads 0.
REQ-036 CLEAR-phase requests: write 0xFFFFFFFF to 0x8 during CLEAR -> ErrFlag stays 0 and word 2 reads 0 after READY.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder: FSM states,
// error codes, default geometry and the request classification rule.
package data_mem_responder_pkg;

  localparam int DEF_DEPTH = 256;
  localparam int DEF_IDX_W = 8;
  localparam int WORD_W    = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE     = 2'd0;
  localparam err_code_t ERR_MISALIGN = 2'd1;
  localparam err_code_t ERR_RANGE    = 2'd2;
  localparam err_code_t ERR_CONFLICT = 2'd3;

  // Classify one request. Conflict outranks misalignment, which outranks
  // out-of-range. An idle request (no read, no write) is never an error.
  function automatic err_code_t classify_req(input logic        rd,
                                             input logic        wr,
                                             input logic [31:0] addr,
                                             input int          idx_w);
    err_code_t code;
    code = ERR_NONE;
    if (rd && wr) begin
      code = ERR_CONFLICT;
    end else if (rd || wr) begin
      if (addr[1:0] != 2'b00) begin
        code = ERR_MISALIGN;
      end else if ((addr >> (idx_w + 2)) != 32'd0) begin
        code = ERR_RANGE;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Bus between the pipeline MEM stage (master) and the data memory (slave).
interface data_mem_responder_if;

  logic        MemRead;
  logic        MemWrite;
  logic [31:0] DataAddr;
  logic [31:0] WriteMem;
  logic [31:0] DataMemOut;
  logic        MemReady;
  logic        ErrFlag;
  logic [1:0]  ErrCode;

  modport master (
    output MemRead, MemWrite, DataAddr, WriteMem,
    input  DataMemOut, MemReady, ErrFlag, ErrCode
  );

  modport slave (
    input  MemRead, MemWrite, DataAddr, WriteMem,
    output DataMemOut, MemReady, ErrFlag, ErrCode
  );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// Word storage: one asynchronous read port, one synchronous write port.
// Contents are deliberately not reset; the owner clears them explicitly.
module dmem_array
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Combinational read returns pre-edge contents during a same-cycle write.
  assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder for the pipeline MEM stage. After reset it walks
// every word writing zero (CLEAR), then services single-cycle reads and
// writes (READY), rejecting conflicting, misaligned and out-of-range
// requests with a sticky error flag and a last-error code.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic              err_flag;
  err_code_t         err_code;

  logic              ready;
  err_code_t         req_err;
  logic              req_ok;
  logic              rd_ok;
  logic              wr_ok;
  logic [IDX_W-1:0]  word_idx;

  logic              arr_we;
  logic [IDX_W-1:0]  arr_waddr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;

  assign ready    = (state == READY);
  assign req_err  = classify_req(bus.MemRead, bus.MemWrite, bus.DataAddr, IDX_W);
  assign req_ok   = ready && (req_err == ERR_NONE);
  assign rd_ok    = req_ok && bus.MemRead;
  assign wr_ok    = req_ok && bus.MemWrite;
  assign word_idx = bus.DataAddr[IDX_W+1:2];

  // During CLEAR the write port belongs to the clear walker; in READY it
  // takes only accepted stores.
  assign arr_we    = !ready || wr_ok;
  assign arr_waddr = ready ? word_idx : clr_idx;
  assign arr_wdata = ready ? bus.WriteMem : '0;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (word_idx),
    .rdata (arr_rdata)
  );

  // Clear-walk / service FSM with the sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLEAR;
      clr_idx  <= '0;
      err_flag <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state   <= READY;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        READY: begin
          if (req_err != ERR_NONE) begin
            err_flag <= 1'b1;
            err_code <= req_err;
          end
        end
        default: begin
          state   <= CLEAR;
          clr_idx <= '0;
        end
      endcase
    end
  end

  assign bus.DataMemOut = rd_ok ? arr_rdata : '0;
  assign bus.MemReady   = ready;
  assign bus.ErrFlag    = err_flag;
  assign bus.ErrCode    = err_code;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder with a word-array reference model.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH(256), .IDX_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: memory as a plain word array plus error state.
  logic [31:0] ref_mem [256];
  bit          ref_ready;
  bit          ref_ef;
  logic [1:0]  ref_ec;

  function automatic void ref_reset();
    ref_ready = 1'b0;
    ref_ef    = 1'b0;
    ref_ec    = 2'd0;
  endfunction

  function automatic void ref_cleared();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    ref_ready = 1'b1;
  endfunction

  function automatic logic [31:0] ref_step(input bit rd, input bit wr,
                                           input logic [31:0] addr,
                                           input logic [31:0] wdata);
    logic [31:0] dout;
    int          code;
    dout = 32'h0;
    if (!ref_ready || !(rd || wr)) return dout;
    if (rd && wr)              code = 3;
    else if (addr % 4 != 0)    code = 1;
    else if (addr >= 32'd1024) code = 2;
    else                       code = 0;
    if (code != 0) begin
      ref_ef = 1'b1;
      ref_ec = 2'(code);
      return dout;
    end
    if (rd) dout = ref_mem[addr / 4];
    else    ref_mem[addr / 4] = wdata;
    return dout;
  endfunction

  // One request cycle: entered and left just after a rising edge.
  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] dout,
                           output logic ef, output logic [1:0] ec);
    bus.MemRead  = rd;
    bus.MemWrite = wr;
    bus.DataAddr = addr;
    bus.WriteMem = wdata;
    #3;
    dout = bus.DataMemOut;
    @(posedge clk);
    #1;
    ef = bus.ErrFlag;
    ec = bus.ErrCode;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.MemReady === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    int n;
    @(posedge clk);
    #1;
    bus.MemRead  = 1'b1;
    bus.DataAddr = 32'h0;
    #1;
    total++; if (bus.MemReady !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", bus.MemReady); end
    total++; if (bus.ErrFlag !== 1'b0) begin bad++; $display("FAIL rst_errflag got=%b exp=0", bus.ErrFlag); end
    total++; if (bus.ErrCode !== 2'd0) begin bad++; $display("FAIL rst_errcode got=%0d exp=0", bus.ErrCode); end
    total++; if (bus.DataMemOut !== 32'h0) begin bad++; $display("FAIL rst_dout got=%h exp=0", bus.DataMemOut); end
    bus.MemRead = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    ref_reset();
    wait_ready(n);
    total++; if (n != 256) begin bad++; $display("FAIL clear_cycles got=%0d exp=256", n); end
    ref_cleared();
  endtask

  task automatic test_clear_readback();
    logic [31:0] d, e;
    logic ef;
    logic [1:0] ec;
    for (int i = 0; i < 256; i++) begin
      e = ref_step(1'b1, 1'b0, 32'(i * 4), 32'h0);
      do_access(1'b1, 1'b0, 32'(i * 4), 32'h0, d, ef, ec);
      total++; if (d !== e || d !== 32'h0) begin bad++; $display("FAIL clear_word[%0d] got=%h exp=00000000", i, d); end
    end
    total++; if (ef !== 1'b0) begin bad++; $display("FAIL clear_errflag got=%b exp=0", ef); end
  endtask

  task automatic test_write_read();
    logic [31:0] d, e;
    logic ef;
    logic [1:0] ec;
    e = ref_step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, d, ef, ec);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL wr_cycle_dout got=%h exp=00000000", d); end
    total++; if (ef !== 1'b0) begin bad++; $display("FAIL wr_errflag got=%b exp=0", ef); end
    e = ref_step(1'b1, 1'b0, 32'h10, 32'h0);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, d, ef, ec);
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_after_wr got=%h exp=deadbeef", d); end
  endtask

  task automatic test_misaligned();
    logic [31:0] d, e;
    logic ef;
    logic [1:0] ec;
    e = ref_step(1'b0, 1'b1, 32'h13, 32'hCAFEF00D);
    do_access(1'b0, 1'b1, 32'h13, 32'hCAFEF00D, d, ef, ec);
    total++; if (ef !== 1'b1) begin bad++; $display("FAIL misal_errflag got=%b exp=1", ef); end
    total++; if (ec !== 2'd1) begin bad++; $display("FAIL misal_errcode got=%0d exp=1", ec); end
    e = ref_step(1'b1, 1'b0, 32'h10, 32'h0);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, d, ef, ec);
    total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL misal_word4 got=%h exp=deadbeef", d); end
    total++; if (ef !== 1'b1) begin bad++; $display("FAIL misal_sticky got=%b exp=1", ef); end
    total++; if (ec !== 2'd1) begin bad++; $display("FAIL misal_code_kept got=%0d exp=1", ec); end
  endtask

  task automatic test_range_conflict();
    logic [31:0] d, e;
    logic ef;
    logic [1:0] ec;
    e = ref_step(1'b1, 1'b0, 32'h400, 32'h0);
    do_access(1'b1, 1'b0, 32'h400, 32'h0, d, ef, ec);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL oor_dout got=%h exp=00000000", d); end
    total++; if (ec !== 2'd2) begin bad++; $display("FAIL oor_errcode got=%0d exp=2", ec); end
    e = ref_step(1'b1, 1'b1, 32'h0, 32'h55AA55AA);
    do_access(1'b1, 1'b1, 32'h0, 32'h55AA55AA, d, ef, ec);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL conf_dout got=%h exp=00000000", d); end
    total++; if (ec !== 2'd3) begin bad++; $display("FAIL conf_errcode got=%0d exp=3", ec); end
    e = ref_step(1'b1, 1'b0, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, d, ef, ec);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL conf_word0 got=%h exp=00000000", d); end
    e = ref_step(1'b0, 1'b1, 32'h401, 32'h1);
    do_access(1'b0, 1'b1, 32'h401, 32'h1, d, ef, ec);
    total++; if (ec !== 2'd1) begin bad++; $display("FAIL misal_over_oor got=%0d exp=1", ec); end
  endtask

  task automatic test_random();
    logic [31:0] d, e, addr, wd;
    logic ef;
    logic [1:0] ec;
    bit rd, wr;
    int k, r;
    for (int i = 0; i < 400; i++) begin
      k = int'($urandom_range(0, 9));
      rd = (k <= 3) || (k == 8);
      wr = (k >= 4 && k <= 8);
      r = int'($urandom_range(0, 9));
      if (r <= 3)      addr = 32'($urandom_range(0, 15)) << 2;
      else if (r <= 5) addr = 32'($urandom_range(0, 255)) << 2;
      else if (r == 6) addr = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 7) addr = (32'($urandom_range(1, 65535)) << 10) | (32'($urandom_range(0, 255)) << 2);
      else if (r == 8) addr = (32'($urandom_range(1, 65535)) << 10) | 32'($urandom_range(1, 3));
      else             addr = $urandom;
      wd = $urandom;
      e = ref_step(rd, wr, addr, wd);
      do_access(rd, wr, addr, wd, d, ef, ec);
      total++; if (d !== e) begin bad++; $display("FAIL rand_dout[%0d] addr=%h got=%h exp=%h", i, addr, d, e); end
      total++; if (ef !== ref_ef || ec !== ref_ec) begin
        bad++; $display("FAIL rand_err[%0d] addr=%h got=%b/%0d exp=%b/%0d", i, addr, ef, ec, ref_ef, ref_ec);
      end
    end
  endtask

  task automatic test_clear_requests();
    logic [31:0] d, e;
    logic ef;
    logic [1:0] ec;
    int n;
    rst = 1'b0;
    #2;
    total++; if (bus.ErrFlag !== 1'b0) begin bad++; $display("FAIL clrreq_rst_errflag got=%b exp=0", bus.ErrFlag); end
    rst = 1'b1;
    ref_reset();
    for (int i = 0; i < 50; i++) begin
      case (i % 3)
        0: do_access(1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, d, ef, ec);
        1: do_access(1'b1, 1'b0, 32'h8, 32'h0, d, ef, ec);
        default: do_access(1'b1, 1'b1, 32'h3, 32'hFFFFFFFF, d, ef, ec);
      endcase
      total++; if (d !== 32'h0 || ef !== 1'b0 || bus.MemReady !== 1'b0) begin
        bad++; $display("FAIL clrreq[%0d] got=%h/%b/%b exp=00000000/0/0", i, d, ef, bus.MemReady);
      end
    end
    wait_ready(n);
    total++; if (n + 50 != 256) begin bad++; $display("FAIL clrreq_cycles got=%0d exp=256", n + 50); end
    ref_cleared();
    e = ref_step(1'b1, 1'b0, 32'h8, 32'h0);
    do_access(1'b1, 1'b0, 32'h8, 32'h0, d, ef, ec);
    total++; if (d !== 32'h0 || d !== e) begin bad++; $display("FAIL clrreq_word2 got=%h exp=00000000", d); end
    total++; if (ef !== 1'b0) begin bad++; $display("FAIL clrreq_errflag got=%b exp=0", ef); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    logic ef;
    logic [1:0] ec;
    int n;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    ref_reset();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    #1;
    total++; if (bus.MemReady !== 1'b0) begin bad++; $display("FAIL midclr_ready got=%b exp=0", bus.MemReady); end
    rst = 1'b1;
    wait_ready(n);
    total++; if (n != 256) begin bad++; $display("FAIL midclr_cycles got=%0d exp=256", n); end
    ref_cleared();
    e = ref_step(1'b0, 1'b1, 32'h0, 32'h12345678);
    do_access(1'b0, 1'b1, 32'h0, 32'h12345678, d, ef, ec);
    e = ref_step(1'b1, 1'b0, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, d, ef, ec);
    total++; if (d !== 32'h12345678) begin bad++; $display("FAIL midrdy_word0 got=%h exp=12345678", d); end
    e = ref_step(1'b0, 1'b1, 32'h6, 32'h0);
    do_access(1'b0, 1'b1, 32'h6, 32'h0, d, ef, ec);
    total++; if (ef !== 1'b1 || ec !== 2'd1) begin bad++; $display("FAIL midrdy_err got=%b/%0d exp=1/1", ef, ec); end
    rst = 1'b0;
    #1;
    total++; if (bus.MemReady !== 1'b0) begin bad++; $display("FAIL midrdy_ready got=%b exp=0", bus.MemReady); end
    total++; if (bus.ErrFlag !== 1'b0 || bus.ErrCode !== 2'd0) begin
      bad++; $display("FAIL midrdy_errclr got=%b/%0d exp=0/0", bus.ErrFlag, bus.ErrCode);
    end
    rst = 1'b1;
    ref_reset();
    wait_ready(n);
    total++; if (n != 256) begin bad++; $display("FAIL midrdy_cycles got=%0d exp=256", n); end
    ref_cleared();
    e = ref_step(1'b1, 1'b0, 32'h0, 32'h0);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, d, ef, ec);
    total++; if (d !== 32'h0 || d !== e) begin bad++; $display("FAIL midrdy_word0_clr got=%h exp=00000000", d); end
  endtask

  initial begin
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.DataAddr = 32'h0;
    bus.WriteMem = 32'h0;
    ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
    test_reset();
    test_clear_readback();
    test_write_read();
    test_misaligned();
    test_range_conflict();
    test_random();
    test_clear_requests();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
